// File: rtl/ethernet_mmio_arbiter.sv
// Two-requester round-robin arbiter for the Ethernet controller MMIO port.
// One transaction in flight; converts valid/ready requests into single-cycle
// port enables, captures the synchronous read data / decode error and holds
// the response for the owning requester until it is accepted.
module ethernet_mmio_arbiter #(
  parameter int unsigned data_width_p    = 32,
  parameter int unsigned addr_width_p    = 14,
  parameter int unsigned size_width_p    = 2,
  parameter int unsigned err_cnt_width_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [1:0]                   req_v_i,
  output logic [1:0]                   req_ready_o,
  input  logic [1:0]                   req_we_i,
  input  logic [2*addr_width_p-1:0]    req_addr_i,
  input  logic [2*size_width_p-1:0]    req_size_i,
  input  logic [2*data_width_p-1:0]    req_wdata_i,
  output logic [1:0]                   resp_v_o,
  input  logic [1:0]                   resp_ready_i,
  output logic [data_width_p-1:0]      resp_rdata_o,
  output logic                         resp_err_o,
  output logic [addr_width_p-1:0]      mm_addr_o,
  output logic                         mm_write_en_o,
  output logic                         mm_read_en_o,
  output logic [size_width_p-1:0]      mm_op_size_o,
  output logic [data_width_p-1:0]      mm_write_data_o,
  input  logic [data_width_p-1:0]      mm_read_data_i,
  input  logic                         mm_decode_error_i,
  output logic [err_cnt_width_p-1:0]   err_count_o,
  output logic                         busy_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  state_e                       state_q, state_d;
  logic                         rr_last_q, rr_last_d;
  logic                         gnt_q, gnt_d;
  logic                         we_q, we_d;
  logic [addr_width_p-1:0]      addr_q, addr_d;
  logic [size_width_p-1:0]      size_q, size_d;
  logic [data_width_p-1:0]      wdata_q, wdata_d;
  logic [data_width_p-1:0]      rdata_q, rdata_d;
  logic                         err_q, err_d;
  logic [err_cnt_width_p-1:0]   err_cnt_q, err_cnt_d;

  logic                         gnt_sel;

  // Grant choice: alternate when both request, otherwise take the only one.
  always_comb begin
    gnt_sel = 1'b0;
    if (&req_v_i) begin
      gnt_sel = ~rr_last_q;
    end else begin
      gnt_sel = req_v_i[1];
    end
  end

  // Next-state, payload latching, response capture and error counting.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (|req_v_i) begin
          gnt_d   = gnt_sel;
          we_d    = gnt_sel ? req_we_i[1] : req_we_i[0];
          addr_d  = gnt_sel ? req_addr_i[addr_width_p +: addr_width_p]
                            : req_addr_i[0 +: addr_width_p];
          size_d  = gnt_sel ? req_size_i[size_width_p +: size_width_p]
                            : req_size_i[0 +: size_width_p];
          wdata_d = gnt_sel ? req_wdata_i[data_width_p +: data_width_p]
                            : req_wdata_i[0 +: data_width_p];
          rdata_d = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        err_d = mm_decode_error_i;
        if (mm_decode_error_i && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + {{(err_cnt_width_p-1){1'b0}}, 1'b1};
        end
        state_d = we_q ? StResp : StCapture;
      end
      StCapture: begin
        // Data is captured even when the port flagged a decode error.
        rdata_d = mm_read_data_i;
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready_i[gnt_q]) begin
          rr_last_d = gnt_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Decoded outputs; everything idles at zero outside its owning state.
  always_comb begin
    req_ready_o     = '0;
    resp_v_o        = '0;
    resp_rdata_o    = '0;
    resp_err_o      = 1'b0;
    mm_addr_o       = '0;
    mm_write_en_o   = 1'b0;
    mm_read_en_o    = 1'b0;
    mm_op_size_o    = '0;
    mm_write_data_o = '0;

    unique case (state_q)
      StIdle: begin
        if (|req_v_i) begin
          req_ready_o[gnt_sel] = 1'b1;
        end
      end
      StIssue: begin
        mm_addr_o     = addr_q;
        mm_op_size_o  = size_q;
        mm_write_en_o = we_q;
        mm_read_en_o  = ~we_q;
        if (we_q) begin
          mm_write_data_o = wdata_q;
        end
      end
      StResp: begin
        resp_v_o[gnt_q] = 1'b1;
        resp_err_o      = err_q;
        if (!we_q) begin
          resp_rdata_o = rdata_q;
        end
      end
      default: ;
    endcase
  end

  assign err_count_o = err_cnt_q;
  assign busy_o      = (state_q != StIdle);

  // State and datapath registers; reset discards any in-flight transaction.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= StIdle;
      rr_last_q <= 1'b1;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_ethernet_mmio_arbiter.sv
// Directed bench for ethernet_mmio_arbiter with a small behavioural MMIO port.
module tb_ethernet_mmio_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_v;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [27:0] req_addr;
  logic [3:0]  req_size;
  logic [63:0] req_wdata;
  logic [1:0]  resp_v;
  logic [1:0]  resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [13:0] mm_addr;
  logic        mm_write_en;
  logic        mm_read_en;
  logic [1:0]  mm_op_size;
  logic [31:0] mm_write_data;
  logic [31:0] mm_read_data;
  logic        mm_decode_error;
  logic [7:0]  err_count;
  logic        busy;

  int vectors;
  int miscompares;

  ethernet_mmio_arbiter dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .req_v_i          (req_v),
    .req_ready_o      (req_ready),
    .req_we_i         (req_we),
    .req_addr_i       (req_addr),
    .req_size_i       (req_size),
    .req_wdata_i      (req_wdata),
    .resp_v_o         (resp_v),
    .resp_ready_i     (resp_ready),
    .resp_rdata_o     (resp_rdata),
    .resp_err_o       (resp_err),
    .mm_addr_o        (mm_addr),
    .mm_write_en_o    (mm_write_en),
    .mm_read_en_o     (mm_read_en),
    .mm_op_size_o     (mm_op_size),
    .mm_write_data_o  (mm_write_data),
    .mm_read_data_i   (mm_read_data),
    .mm_decode_error_i(mm_decode_error),
    .err_count_o      (err_count),
    .busy_o           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port model: fixed read contents, decode error at 0x1014.
  function automatic logic [31:0] rd_func(input logic [13:0] a);
    if (a == 14'h1004) return 32'h0000_05EA;
    return 32'hA5A5_0000 | {18'h0, a};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mm_read_data <= '0;
    else if (mm_read_en) mm_read_data <= rd_func(mm_addr);
  end

  assign mm_decode_error = (mm_read_en | mm_write_en) && (mm_addr == 14'h1014);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic we, input logic [13:0] a,
                         input logic [31:0] d, input logic [1:0] sz);
    req_we[r]          = we;
    req_addr[r*14 +: 14] = a;
    req_wdata[r*32 +: 32] = d;
    req_size[r*2 +: 2]  = sz;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req_v      = '0;
    resp_ready = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Complete one transaction for requester r without detailed checks.
  task automatic do_txn(input int r, input logic we, input logic [13:0] a);
    int n;
    set_req(r, we, a, 32'h1234_5678, 2'd2);
    req_v[r] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[r] && n < 8) begin tick(); n++; end
    if (!req_ready[r]) check("txn_accept_timeout", {31'b0, req_ready[r]}, 32'd1);
    tick();
    req_v[r] = 1'b0;
    resp_ready[r] = 1'b1;
    n = 0;
    while (!resp_v[r] && n < 8) begin tick(); n++; end
    if (!resp_v[r]) check("txn_resp_timeout", {31'b0, resp_v[r]}, 32'd1);
    tick();
    resp_ready = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    req_we      = '0;
    req_addr    = '0;
    req_size    = '0;
    req_wdata   = '0;
    do_reset();

    // Reset state
    check("rst_busy",   {31'b0, busy}, 32'd0);
    check("rst_resp_v", {30'b0, resp_v}, 32'd0);
    check("rst_errcnt", {24'b0, err_count}, 32'd0);
    check("rst_mm_addr", {18'b0, mm_addr}, 32'd0);

    // 1: req0 write
    set_req(0, 1'b1, 14'h0800, 32'hDEAD_BEEF, 2'd2);
    req_v = 2'b01;
    #1;
    check("t1_ready", {30'b0, req_ready}, 32'b01);
    tick();
    req_v = '0;
    check("t1_wen",   {31'b0, mm_write_en}, 32'd1);
    check("t1_ren",   {31'b0, mm_read_en}, 32'd0);
    check("t1_addr",  {18'b0, mm_addr}, 32'h0800);
    check("t1_wdata", mm_write_data, 32'hDEAD_BEEF);
    check("t1_size",  {30'b0, mm_op_size}, 32'd2);
    tick();
    check("t1_resp_v", {30'b0, resp_v}, 32'b01);
    check("t1_err",    {31'b0, resp_err}, 32'd0);
    check("t1_rdata",  resp_rdata, 32'd0);
    check("t1_wen_off", {31'b0, mm_write_en}, 32'd0);
    resp_ready = 2'b01;
    tick();
    resp_ready = '0;
    check("t1_idle", {31'b0, busy}, 32'd0);

    // 2: req1 read
    set_req(1, 1'b0, 14'h1004, 32'h0, 2'd2);
    req_v = 2'b10;
    #1;
    check("t2_ready", {30'b0, req_ready}, 32'b10);
    tick();
    req_v = '0;
    check("t2_ren",  {31'b0, mm_read_en}, 32'd1);
    check("t2_wen",  {31'b0, mm_write_en}, 32'd0);
    check("t2_addr", {18'b0, mm_addr}, 32'h1004);
    check("t2_wdata0", mm_write_data, 32'd0);
    tick();
    check("t2_cap_resp_v", {30'b0, resp_v}, 32'd0);
    check("t2_cap_ren", {31'b0, mm_read_en}, 32'd0);
    tick();
    check("t2_resp_v", {30'b0, resp_v}, 32'b10);
    check("t2_rdata",  resp_rdata, 32'h5EA);
    resp_ready = 2'b10;
    tick();
    resp_ready = '0;

    // 3: both valid after reset, four reads alternate 0,1,0,1
    do_reset();
    set_req(0, 1'b0, 14'h0100, 32'h0, 2'd2);
    set_req(1, 1'b0, 14'h0200, 32'h0, 2'd2);
    req_v      = 2'b11;
    resp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [1:0]  exp_g;
      logic [13:0] exp_a;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (i % 2 == 0) ? 14'h0100 : 14'h0200;
      #1;
      check("t3_grant", {30'b0, req_ready}, {30'b0, exp_g});
      tick();
      check("t3_ren",  {31'b0, mm_read_en}, 32'd1);
      check("t3_addr", {18'b0, mm_addr}, {18'b0, exp_a});
      tick();
      check("t3_cap_en", {30'b0, mm_read_en, mm_write_en}, 32'd0);
      check("t3_cap_ready", {30'b0, req_ready}, 32'd0);
      tick();
      check("t3_resp_v", {30'b0, resp_v}, {30'b0, exp_g});
      check("t3_rdata",  resp_rdata, rd_func(exp_a));
      check("t3_resp_en", {30'b0, mm_read_en, mm_write_en}, 32'd0);
      tick();
    end
    req_v      = '0;
    resp_ready = '0;

    // 4: decode error and saturating counter
    do_reset();
    set_req(0, 1'b0, 14'h1014, 32'h0, 2'd2);
    req_v = 2'b01;
    #1;
    check("t4_ready", {30'b0, req_ready}, 32'b01);
    tick();
    req_v = '0;
    check("t4_cnt_before", {24'b0, err_count}, 32'd0);
    tick();
    check("t4_cnt_after", {24'b0, err_count}, 32'd1);
    tick();
    check("t4_resp_err", {31'b0, resp_err}, 32'd1);
    check("t4_rdata", resp_rdata, 32'hA5A5_1014);
    resp_ready = 2'b01;
    tick();
    resp_ready = '0;
    for (int i = 0; i < 254; i++) do_txn(0, 1'b1, 14'h1014);
    check("t4_cnt_255", {24'b0, err_count}, 32'hFF);
    for (int i = 0; i < 45; i++) do_txn(0, 1'b0, 14'h1014);
    check("t4_cnt_sat", {24'b0, err_count}, 32'hFF);
    do_txn(0, 1'b0, 14'h0100);
    check("t4_no_err_cnt", {24'b0, err_count}, 32'hFF);

    // 5: response held under backpressure, non-owner ready ignored
    set_req(0, 1'b0, 14'h0100, 32'h0, 2'd2);
    set_req(1, 1'b0, 14'h0200, 32'h0, 2'd2);
    req_v = 2'b01;
    #1;
    check("t5_ready0", {30'b0, req_ready}, 32'b01);
    tick();
    req_v = 2'b10;
    check("t5_issue_ready", {30'b0, req_ready}, 32'd0);
    tick();
    tick();
    resp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_v", {30'b0, resp_v}, 32'b01);
      check("t5_hold_rdata", resp_rdata, 32'hA5A5_0100);
      check("t5_hold_ready", {30'b0, req_ready}, 32'd0);
      check("t5_hold_en", {30'b0, mm_read_en, mm_write_en}, 32'd0);
      tick();
    end
    resp_ready = 2'b01;
    tick();
    resp_ready = '0;
    check("t5_req1_ready", {30'b0, req_ready}, 32'b10);
    check("t5_resp_v_off", {30'b0, resp_v}, 32'd0);
    tick();
    req_v = '0;
    check("t5_req1_addr", {18'b0, mm_addr}, 32'h0200);
    tick();
    tick();
    check("t5_req1_resp", {30'b0, resp_v}, 32'b10);
    resp_ready = 2'b10;
    tick();
    resp_ready = '0;

    // 6: reset during CAPTURE
    set_req(1, 1'b0, 14'h0200, 32'h0, 2'd2);
    req_v = 2'b10;
    tick();
    req_v = '0;
    tick();
    check("t6_busy_cap", {31'b0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_resp_v", {30'b0, resp_v}, 32'd0);
    check("t6_en", {30'b0, mm_read_en, mm_write_en}, 32'd0);
    check("t6_errcnt", {24'b0, err_count}, 32'd0);
    check("t6_rdata", resp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    req_v = 2'b11;
    #1;
    check("t6_rr_favour0", {30'b0, req_ready}, 32'b01);
    tick();
    req_v = '0;
    tick();
    check("t6_no_resp", {30'b0, resp_v}, 32'd0);
    repeat (3) tick();
    resp_ready = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
